uart_rx_oversample: RTL and testbench

Oversampling UART receiver that sits between the `uart_rx` pin and the receive FIFO of the memory-mapped serial port. It synchronizes the asynchronous line and detects start bits at 8x the bit rate. It samples each bit at its centre and deserializes 8N1 frames LSB first. Each good character is presented as a single-cycle `rx_char_valid` pulse suitable for a FIFO enqueue; stop-bit violations are flagged separately.

---
 rtl/uart_rx_oversample.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversample
// Description : 8x oversampling 8N1 UART receiver. Synchronizes the serial
//               line, detects start bits and samples each bit at its centre.
//               Each good character produces a one-cycle rx_char_valid pulse.
//               A low stop bit produces a one-cycle frame_error pulse.
//               Optional build macro UART_RX_MAJORITY_VOTE_EN selects a
//               majority vote of ticks 3/4/5 instead of the tick-4 sample.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversample #(
    parameter int BAUD_DIVIDE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_char,
    output logic       rx_char_valid,
    output logic       frame_error
);

    localparam int c_PRESC_W = $clog2(BAUD_DIVIDE + 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_RELOAD = c_PRESC_W'(BAUD_DIVIDE - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE    = c_PRESC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [c_PRESC_W-1:0] r_presc;
    logic [2:0]           r_tick_cnt;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift;
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic                 r_samp3;
`endif
    logic                 r_samp4;

    logic                 w_tick;
    logic [2:0]           w_tick_idx;
    logic                 w_in_frame;
    logic                 w_bit;

    // A tick fires whenever the prescaler has run down; w_tick_idx is the
    // index of the tick occurring in this cycle (wraps 7 -> 0).
    assign w_tick     = (r_presc == '0);
    assign w_tick_idx = r_tick_cnt + 3'd1;
    assign w_in_frame = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

    // Bit decision taken at tick 5; r_sync2 is the live tick-5 sample.
`ifdef UART_RX_MAJORITY_VOTE_EN
    assign w_bit = (r_samp3 & r_samp4) | (r_samp3 & r_sync2) | (r_samp4 & r_sync2);
`else
    assign w_bit = r_samp4;
`endif

    // Two-flop synchronizer for the asynchronous line, idling high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Capture the early mid-bit samples used by the tick-5 decision.
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef UART_RX_MAJORITY_VOTE_EN
            r_samp3 <= 1'b1;
`endif
            r_samp4 <= 1'b1;
        end else if (w_in_frame && w_tick) begin
`ifdef UART_RX_MAJORITY_VOTE_EN
            if (w_tick_idx == 3'd3) begin
                r_samp3 <= r_sync2;
            end
`endif
            if (w_tick_idx == 3'd4) begin
                r_samp4 <= r_sync2;
            end
        end
    end

    // Frame FSM: timing counters, deserializer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_presc       <= '0;
            r_tick_cnt    <= 3'd0;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            rx_char       <= 8'h00;
            rx_char_valid <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            rx_char_valid <= 1'b0;
            frame_error   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The detection cycle itself is tick 0 of the start bit.
                    if (!r_sync2) begin
                        r_state    <= S_START;
                        r_presc    <= c_PRESC_RELOAD;
                        r_tick_cnt <= 3'd0;
                    end
                end
                S_WAIT_HIGH: begin
                    // Stay here through a break until the line returns high.
                    if (r_sync2) begin
                        r_state <= S_IDLE;
                    end
                end
                S_START, S_DATA, S_STOP: begin
                    if (!w_tick) begin
                        r_presc <= r_presc - c_PRESC_ONE;
                    end else begin
                        r_presc    <= c_PRESC_RELOAD;
                        r_tick_cnt <= w_tick_idx;
                        if (w_tick_idx == 3'd5) begin
                            if (r_state == S_START) begin
                                if (w_bit) begin
                                    r_state <= S_IDLE;
                                end
                            end else if (r_state == S_DATA) begin
                                r_shift <= {w_bit, r_shift[7:1]};
                            end else begin
                                if (w_bit) begin
                                    rx_char       <= r_shift;
                                    rx_char_valid <= 1'b1;
                                    r_state       <= S_IDLE;
                                end else begin
                                    frame_error <= 1'b1;
                                    r_state     <= S_WAIT_HIGH;
                                end
                            end
                        end else if (w_tick_idx == 3'd0) begin
                            if (r_state == S_START) begin
                                r_state   <= S_DATA;
                                r_bit_cnt <= 3'd0;
                            end else if (r_state == S_DATA) begin
                                if (r_bit_cnt == 3'd7) begin
                                    r_state <= S_STOP;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 3'd1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversample.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_oversample
// Description : Self-checking bench for uart_rx_oversample. Two instances
//               (BAUD_DIVIDE 1 and 4) share clock and reset. Line and reset
//               are logged per clock; a scanning reference model derives the
//               expected output events from the logged waveform.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversample;

    localparam int MAXC = 30000;
    localparam int B0   = 1;
    localparam int B1   = 4;

    typedef struct {
        int         inst;
        int         e;
        bit         fe;
        logic [7:0] ch;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       line_v [2];
    logic [7:0] ch0, ch1;
    logic       v0, v1, fe0, fe1;

    logic       ln [2][MAXC];
    logic       rs_log [MAXC];
    int         cyc = 0;
    int         both_seen = 0;
    ev_t        obs_q[$];
    ev_t        exp_q[$];
    ev_t        got_q[$];
    logic [7:0] lastc [2];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_rx_oversample #(.BAUD_DIVIDE(B0)) dut0 (
        .clk(clk), .reset(reset), .uart_rx(line_v[0]),
        .rx_char(ch0), .rx_char_valid(v0), .frame_error(fe0)
    );

    uart_rx_oversample #(.BAUD_DIVIDE(B1)) dut1 (
        .clk(clk), .reset(reset), .uart_rx(line_v[1]),
        .rx_char(ch1), .rx_char_valid(v1), .frame_error(fe1)
    );

    // Log what each DUT sees at every active edge.
    always @(posedge clk) begin
        if (cyc < MAXC) begin
            ln[0][cyc] <= line_v[0];
            ln[1][cyc] <= line_v[1];
            rs_log[cyc] <= reset;
        end
        cyc <= cyc + 1;
    end

    // Record output pulses, tagged with the edge that produced them.
    always @(negedge clk) begin
        if (v0 === 1'b1 || fe0 === 1'b1) obs_q.push_back(ev_t'{0, cyc - 1, fe0, ch0});
        if (v1 === 1'b1 || fe1 === 1'b1) obs_q.push_back(ev_t'{1, cyc - 1, fe1, ch1});
        if ((v0 === 1'b1 && fe0 === 1'b1) || (v1 === 1'b1 && fe1 === 1'b1)) both_seen <= both_seen + 1;
    end

    // Synchronized line value seen by the receiver at edge c.
    function automatic logic rxs(input int i, input int c);
        if (c < 2) return 1'b1;
        if (rs_log[c-1] === 1'b1 || rs_log[c-2] === 1'b1) return 1'b1;
        return ln[i][c-2];
    endfunction

    // Decided value of bit n of a frame whose start was detected at t.
    function automatic logic bitval(input int i, input int t, input int n, input int b);
        int base;
        base = t + b * 8 * n;
`ifdef UART_RX_MAJORITY_VOTE_EN
        return (int'(rxs(i, base + 3*b)) + int'(rxs(i, base + 4*b)) + int'(rxs(i, base + 5*b))) >= 2;
`else
        return rxs(i, base + 4*b);
`endif
    endfunction

    // Scan the logged window [s,en) of instance i and build expected and
    // observed event lists.
    function automatic void build(input int i, input int s, input int en);
        int         b;
        int         pos;
        int         t;
        int         endc;
        int         r;
        bit         hit;
        logic [7:0] d;
        b   = (i == 0) ? B0 : B1;
        pos = s;
        r   = 0;
        exp_q.delete();
        got_q.delete();
        foreach (obs_q[k])
            if (obs_q[k].inst == i && obs_q[k].e >= s && obs_q[k].e < en) got_q.push_back(obs_q[k]);
        while (pos < en) begin
            if (rs_log[pos] === 1'b1) begin
                lastc[i] = 8'h00;
                pos++;
                continue;
            end
            if (rxs(i, pos) !== 1'b0) begin
                pos++;
                continue;
            end
            t    = pos;
            endc = bitval(i, t, 0, b) ? t + 5*b : t + 77*b;
            hit  = 1'b0;
            for (int c = t; c <= endc && !hit; c++)
                if (rs_log[c] === 1'b1) begin
                    hit = 1'b1;
                    r   = c;
                end
            if (hit) begin
                pos = r;
                continue;
            end
            if (bitval(i, t, 0, b)) begin
                pos = t + 5*b + 1;
                continue;
            end
            for (int k = 0; k < 8; k++) d[k] = bitval(i, t, k + 1, b);
            if (bitval(i, t, 9, b)) begin
                exp_q.push_back(ev_t'{i, t + 77*b, 1'b0, d});
                lastc[i] = d;
                pos = t + 77*b + 1;
            end else begin
                exp_q.push_back(ev_t'{i, t + 77*b, 1'b1, lastc[i]});
                pos = t + 77*b + 1;
                while (pos < en && rs_log[pos] !== 1'b1 && rxs(i, pos) === 1'b0) pos++;
            end
        end
    endfunction

    // Drive one 8N1 frame; goff inverts the line for one tick, roff pulses
    // reset on that cycle, cut stops the frame early.
    task automatic send_wave(input int i, input logic [7:0] byt, input logic stopb,
                             input int goff, input int roff, input int cut, output int k0);
        int   b;
        int   n;
        logic v;
        b  = (i == 0) ? B0 : B1;
        k0 = cyc;
        for (int j = 0; j < 80*b; j++) begin
            if (j == cut) break;
            n = j / (8*b);
            if (n == 0) v = 1'b0;
            else if (n == 9) v = stopb;
            else v = byt[n-1];
            if (goff >= 0 && j >= goff && j < goff + b) v = ~v;
            line_v[i] = v;
            reset = (j == roff);
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    task automatic idle(input int i, input int n);
        line_v[i] = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ch0 !== 8'h00) begin errors++; $display("FAIL reset_char0 got %h want 00", ch0); end
        checks++; if (v0 !== 1'b0)   begin errors++; $display("FAIL reset_valid0 got %b want 0", v0); end
        checks++; if (fe0 !== 1'b0)  begin errors++; $display("FAIL reset_ferr0 got %b want 0", fe0); end
        checks++; if (ch1 !== 8'h00) begin errors++; $display("FAIL reset_char1 got %h want 00", ch1); end
        checks++; if (v1 !== 1'b0)   begin errors++; $display("FAIL reset_valid1 got %b want 0", v1); end
        checks++; if (fe1 !== 1'b0)  begin errors++; $display("FAIL reset_ferr1 got %b want 0", fe1); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic;
        int s, k0, ti, ii;
        ti = 0;
        s  = cyc;
        send_wave(0, 8'h55, 1'b1, -1, -1, -1, k0);
        idle(0, 60);
        for (int jj = 0; jj < 2; jj++) begin
            ii = (jj == 0) ? 1 - ti : ti;
            build(ii, s, cyc);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL basic_count inst%0d got %0d want %0d", ii, got_q.size(), exp_q.size());
            end else foreach (exp_q[k]) begin
                checks++;
                if (got_q[k].e !== exp_q[k].e || got_q[k].fe !== exp_q[k].fe || got_q[k].ch !== exp_q[k].ch) begin
                    errors++; $display("FAIL basic_event inst%0d got e=%0d fe=%b ch=%h want e=%0d fe=%b ch=%h", ii,
                        got_q[k].e, got_q[k].fe, got_q[k].ch, exp_q[k].e, exp_q[k].fe, exp_q[k].ch);
                end
            end
        end
        checks++;
        if (got_q.size() != 1 || got_q[0].ch !== 8'h55 || got_q[0].fe !== 1'b0 || got_q[0].e != k0 + 2 + 77) begin
            errors++; $display("FAIL basic_spec got n=%0d want one 55 pulse at edge %0d", got_q.size(), k0 + 79);
        end
    endtask

    task automatic test_back_to_back;
        int s, k0, k1, ti, ii;
        ti = 1;
        s  = cyc;
        send_wave(1, 8'hA3, 1'b1, -1, -1, -1, k0);
        send_wave(1, 8'h0F, 1'b1, -1, -1, -1, k1);
        idle(1, 200);
        for (int jj = 0; jj < 2; jj++) begin
            ii = (jj == 0) ? 1 - ti : ti;
            build(ii, s, cyc);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL b2b_count inst%0d got %0d want %0d", ii, got_q.size(), exp_q.size());
            end else foreach (exp_q[k]) begin
                checks++;
                if (got_q[k].e !== exp_q[k].e || got_q[k].fe !== exp_q[k].fe || got_q[k].ch !== exp_q[k].ch) begin
                    errors++; $display("FAIL b2b_event inst%0d got e=%0d fe=%b ch=%h want e=%0d fe=%b ch=%h", ii,
                        got_q[k].e, got_q[k].fe, got_q[k].ch, exp_q[k].e, exp_q[k].fe, exp_q[k].ch);
                end
            end
        end
        checks++;
        if (got_q.size() != 2 || got_q[0].ch !== 8'hA3 || got_q[1].ch !== 8'h0F ||
            got_q[1].e - got_q[0].e != 320 || got_q[0].e != k0 + 2 + 77*4) begin
            errors++; $display("FAIL b2b_spec got n=%0d want A3 then 0F 320 clocks apart", got_q.size());
        end
    endtask

    task automatic test_glitch;
        int s, k0, ti, ii;
        ti = 0;
        s  = cyc;
        line_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        idle(0, 20);
        send_wave(0, 8'h3C, 1'b1, -1, -1, -1, k0);
        idle(0, 60);
        for (int jj = 0; jj < 2; jj++) begin
            ii = (jj == 0) ? 1 - ti : ti;
            build(ii, s, cyc);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL glitch_count inst%0d got %0d want %0d", ii, got_q.size(), exp_q.size());
            end else foreach (exp_q[k]) begin
                checks++;
                if (got_q[k].e !== exp_q[k].e || got_q[k].fe !== exp_q[k].fe || got_q[k].ch !== exp_q[k].ch) begin
                    errors++; $display("FAIL glitch_event inst%0d got e=%0d fe=%b ch=%h want e=%0d fe=%b ch=%h", ii,
                        got_q[k].e, got_q[k].fe, got_q[k].ch, exp_q[k].e, exp_q[k].fe, exp_q[k].ch);
                end
            end
        end
        checks++;
        if (got_q.size() != 1 || got_q[0].ch !== 8'h3C || got_q[0].fe !== 1'b0) begin
            errors++; $display("FAIL glitch_spec got n=%0d want single 3C", got_q.size());
        end
    endtask

    task automatic test_frame_error;
        int s, k0, ti, ii;
        ti = 0;
        s  = cyc;
        send_wave(0, 8'h81, 1'b0, -1, -1, -1, k0);
        line_v[0] = 1'b0;
        repeat (200) @(negedge clk);
        idle(0, 20);
        send_wave(0, 8'h42, 1'b1, -1, -1, -1, k0);
        idle(0, 60);
        for (int jj = 0; jj < 2; jj++) begin
            ii = (jj == 0) ? 1 - ti : ti;
            build(ii, s, cyc);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL ferr_count inst%0d got %0d want %0d", ii, got_q.size(), exp_q.size());
            end else foreach (exp_q[k]) begin
                checks++;
                if (got_q[k].e !== exp_q[k].e || got_q[k].fe !== exp_q[k].fe || got_q[k].ch !== exp_q[k].ch) begin
                    errors++; $display("FAIL ferr_event inst%0d got e=%0d fe=%b ch=%h want e=%0d fe=%b ch=%h", ii,
                        got_q[k].e, got_q[k].fe, got_q[k].ch, exp_q[k].e, exp_q[k].fe, exp_q[k].ch);
                end
            end
        end
        checks++;
        if (got_q.size() != 2 || got_q[0].fe !== 1'b1 || got_q[0].ch !== 8'h3C ||
            got_q[1].fe !== 1'b0 || got_q[1].ch !== 8'h42) begin
            errors++; $display("FAIL ferr_spec got n=%0d want frame_error (char 3C held) then 42", got_q.size());
        end
    endtask

    task automatic test_majority;
        int         s, k0, ti, ii;
        logic [7:0] want;
`ifdef UART_RX_MAJORITY_VOTE_EN
        want = 8'hFF;
`else
        want = 8'hFB;
`endif
        ti = 0;
        s  = cyc;
        send_wave(0, 8'hFF, 1'b1, (8*3 + 4) * B0, -1, -1, k0);
        idle(0, 60);
        for (int jj = 0; jj < 2; jj++) begin
            ii = (jj == 0) ? 1 - ti : ti;
            build(ii, s, cyc);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL vote_count inst%0d got %0d want %0d", ii, got_q.size(), exp_q.size());
            end else foreach (exp_q[k]) begin
                checks++;
                if (got_q[k].e !== exp_q[k].e || got_q[k].fe !== exp_q[k].fe || got_q[k].ch !== exp_q[k].ch) begin
                    errors++; $display("FAIL vote_event inst%0d got e=%0d fe=%b ch=%h want e=%0d fe=%b ch=%h", ii,
                        got_q[k].e, got_q[k].fe, got_q[k].ch, exp_q[k].e, exp_q[k].fe, exp_q[k].ch);
                end
            end
        end
        checks++;
        if (got_q.size() != 1 || got_q[0].ch !== want) begin
            errors++; $display("FAIL vote_spec got n=%0d ch=%h want %h", got_q.size(),
                               (got_q.size() > 0) ? got_q[0].ch : 8'h00, want);
        end
    endtask

    task automatic test_mid_reset;
        int s, k0, ti, ii;
        ti = 0;
        s  = cyc;
        send_wave(0, 8'h99, 1'b1, -1, (8*4 + 4) * B0, (8*4 + 4) * B0 + 1, k0);
        idle(0, 30);
        send_wave(0, 8'h99, 1'b1, -1, -1, -1, k0);
        idle(0, 60);
        for (int jj = 0; jj < 2; jj++) begin
            ii = (jj == 0) ? 1 - ti : ti;
            build(ii, s, cyc);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rst_count inst%0d got %0d want %0d", ii, got_q.size(), exp_q.size());
            end else foreach (exp_q[k]) begin
                checks++;
                if (got_q[k].e !== exp_q[k].e || got_q[k].fe !== exp_q[k].fe || got_q[k].ch !== exp_q[k].ch) begin
                    errors++; $display("FAIL rst_event inst%0d got e=%0d fe=%b ch=%h want e=%0d fe=%b ch=%h", ii,
                        got_q[k].e, got_q[k].fe, got_q[k].ch, exp_q[k].e, exp_q[k].fe, exp_q[k].ch);
                end
            end
        end
        checks++;
        if (got_q.size() != 1 || got_q[0].ch !== 8'h99 || got_q[0].fe !== 1'b0) begin
            errors++; $display("FAIL rst_spec got n=%0d want single 99", got_q.size());
        end
    endtask

    task automatic test_random;
        int         s, k0, b, goff;
        logic [7:0] byt;
        logic       stopb;
        s = cyc;
        for (int i = 0; i < 2; i++) begin
            b = (i == 0) ? B0 : B1;
            for (int f = 0; f < 12; f++) begin
                byt   = 8'($urandom);
                stopb = ($urandom_range(0, 4) != 0);
                goff  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 80*b - 1)) : -1;
                send_wave(i, byt, stopb, goff, -1, -1, k0);
                idle(i, int'($urandom_range(0, 20*b)));
            end
            idle(i, 100*b);
        end
        for (int ii = 0; ii < 2; ii++) begin
            build(ii, s, cyc);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rand_count inst%0d got %0d want %0d", ii, got_q.size(), exp_q.size());
            end else foreach (exp_q[k]) begin
                checks++;
                if (got_q[k].e !== exp_q[k].e || got_q[k].fe !== exp_q[k].fe || got_q[k].ch !== exp_q[k].ch) begin
                    errors++; $display("FAIL rand_event inst%0d got e=%0d fe=%b ch=%h want e=%0d fe=%b ch=%h", ii,
                        got_q[k].e, got_q[k].fe, got_q[k].ch, exp_q[k].e, exp_q[k].fe, exp_q[k].ch);
                end
            end
        end
        checks++;
        if (both_seen != 0) begin
            errors++; $display("FAIL exclusive_pulses got %0d overlapping cycles want 0", both_seen);
        end
    endtask

    initial begin
        reset     = 1'b1;
        line_v[0] = 1'b1;
        line_v[1] = 1'b1;
        lastc[0]  = 8'h00;
        lastc[1]  = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_majority();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
